// File: rtl/padded_window_scanner_pkg.sv
// Shared definitions for the padded-frame window scanner: FSM encoding, derived
// dimensions, and the bit-slice layout of frames and windows.
package padded_window_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   // Side length of the padded frame for an unpadded dimension and kernel side.
   function automatic int padded_dim(input int dim, input int k);
      return dim + k - 1;
   endfunction

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // LSB of padded pixel (row, col) inside a packed frame of padded width pw.
   function automatic int frame_lsb(input int row, input int col, input int pw, input int wl);
      return (row * pw + col) * wl;
   endfunction

   // LSB of element (r, c) inside a packed k x k window.
   function automatic int window_lsb(input int r, input int c, input int k, input int wl);
      return (r * k + c) * wl;
   endfunction

endpackage

// File: rtl/padded_window_scanner_window_mux.sv
// Combinational selector: extracts the kernalSize x kernalSize window whose
// top-left padded pixel sits at (row, col) from the captured frame.
module padded_window_scanner_window_mux
   import padded_window_scanner_pkg::*;
#(
   parameter  int imageWidth  = 3,
   parameter  int imageHeight = 3,
   parameter  int kernalSize  = 3,
   parameter  int wordlength  = 32,
   localparam int PW      = padded_dim(imageWidth, kernalSize),
   localparam int PH      = padded_dim(imageHeight, kernalSize),
   localparam int CW      = index_width(imageWidth),
   localparam int RW      = index_width(imageHeight),
   localparam int FRAME_W = wordlength * PH * PW,
   localparam int WIN_W   = wordlength * kernalSize * kernalSize
)(
   input  logic [FRAME_W-1:0] frame,
   input  logic [RW-1:0]      row,
   input  logic [CW-1:0]      col,
   output logic [WIN_W-1:0]   win
);

   logic [31:0]        offset;
   logic [FRAME_W-1:0] shifted;

   // Shift the window origin down to bit 0 so the element selects are constant.
   assign offset  = (32'(row) * 32'(PW) + 32'(col)) * 32'(wordlength);
   assign shifted = frame >> offset;

   always_comb begin
      win = '0;
      for (int r = 0; r < kernalSize; r++) begin
         for (int c = 0; c < kernalSize; c++) begin
            win[window_lsb(r, c, kernalSize, wordlength) +: wordlength] =
               shifted[frame_lsb(r, c, PW, wordlength) +: wordlength];
         end
      end
   end

endmodule

// File: rtl/padded_window_scanner.sv
// Captures one zero-padded frame on start and streams every "same"-convolution
// window in raster order over a valid/ready handshake, then pulses done.
module padded_window_scanner
   import padded_window_scanner_pkg::*;
#(
   parameter  int imageWidth  = 3,
   parameter  int imageHeight = 3,
   parameter  int kernalSize  = 3,
   parameter  int wordlength  = 32,
   localparam int PW      = padded_dim(imageWidth, kernalSize),
   localparam int PH      = padded_dim(imageHeight, kernalSize),
   localparam int CW      = index_width(imageWidth),
   localparam int RW      = index_width(imageHeight),
   localparam int FRAME_W = wordlength * PH * PW,
   localparam int WIN_W   = wordlength * kernalSize * kernalSize
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] img_in,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [WIN_W-1:0]   win_out,
   output logic [RW-1:0]      win_row,
   output logic [CW-1:0]      win_col,
   output logic               busy,
   output logic               done
);

   localparam logic [CW-1:0] COL_LAST = CW'(imageWidth - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(imageHeight - 1);

   scan_state_e        state, state_next;
   logic [FRAME_W-1:0] frame_reg;
   logic [RW-1:0]      row;
   logic [CW-1:0]      col;
   logic [WIN_W-1:0]   mux_win;
   logic               xfer;
   logic               last_col;
   logic               last_row;

   assign win_valid = (state == SCAN);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign xfer      = win_valid & win_ready;
   assign last_col  = (col == COL_LAST);
   assign last_row  = (row == ROW_LAST);
   assign win_row   = row;
   assign win_col   = col;
   assign win_out   = win_valid ? mux_win : '0;

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (xfer && last_col && last_row) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         // NOTE: frame_reg is a flop bank rather than a RAM, so it is safe to clear on reset.
         frame_reg <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            frame_reg <= img_in;
            row       <= '0;
            col       <= '0;
         end else if (xfer) begin
            // Terminal window leaves row/col parked; DONE follows.
            if (!last_col) begin
               col <= col + 1'b1;
            end else if (!last_row) begin
               col <= '0;
               row <= row + 1'b1;
            end
         end
      end
   end

   padded_window_scanner_window_mux #(
      .imageWidth  (imageWidth),
      .imageHeight (imageHeight),
      .kernalSize  (kernalSize),
      .wordlength  (wordlength)
   ) u_window_mux (
      .frame (frame_reg),
      .row   (row),
      .col   (col),
      .win   (mux_win)
   );

endmodule

// File: doc/padded_window_scanner.md
Name: padded_window_scanner

Overview:
- Sequential stage directly downstream of the combinational padding block.
- Captures one zero-padded image frame from the padding output bus on a start pulse.
- Walks a kernalSize x kernalSize window across the frame in raster order, one window per valid/ready handshake, and feeds the convolution stage.
- Emits exactly imageWidth*imageHeight windows per frame ("same" convolution), then pulses done.

Parameters:
- imageWidth, 3, unpadded image width in pixels.
- imageHeight, 3, unpadded image height in pixels.
- kernalSize, 3, window side; odd, >= 1.
- wordlength, 32, bits per pixel.
- Derived: PW = imageWidth+kernalSize-1, PH = imageHeight+kernalSize-1, CW = $clog2(imageWidth) (min 1), RW = $clog2(imageHeight) (min 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request to capture img_in and begin a scan; sampled only in IDLE.
- img_in  in  wordlength*PH*PW  padded frame. Row i occupies bits [(i+1)*PW*wordlength-1 : i*PW*wordlength]; column j within a row at offset j*wordlength (column 0 at LSB).
- win_valid  out  1  win_out/win_row/win_col hold a valid window.
- win_ready  in  1  consumer accepts the window this cycle.
- win_out  out  wordlength*kernalSize*kernalSize  window; element (r,c) at bits [(r*kernalSize+c+1)*wordlength-1 : (r*kernalSize+c)*wordlength] = padded pixel (win_row+r, win_col+c).
- win_row  out  RW  output-pixel row of current window.
- win_col  out  CW  output-pixel column of current window.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; frame register, row and col cleared to 0.
  - win_valid=0, busy=0, done=0, win_out=0.
  - Takes effect mid-scan; the partial frame is abandoned and no done pulse is issued.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1: frame_reg<=img_in, row<=0, col<=0, go to SCAN.
  - win_valid rises the cycle after start (latency 1).
- SCAN:
  - win_valid=1. win_out is a mux from frame_reg indexed by row/col; it may be combinational from registers but must not depend on win_ready.
  - Transfer occurs when win_valid & win_ready.
  - On transfer with col<imageWidth-1: col++.
  - On transfer with col=imageWidth-1 and row<imageHeight-1: col<=0, row++.
  - On transfer with row=imageHeight-1 and col=imageWidth-1: go to DONE; win_valid=0 next cycle.
  - While win_ready=0, win_out, win_row and win_col hold stable.
  - Back-to-back transfers (win_ready held at 1) yield one window per cycle.
- DONE: done=1 for exactly one cycle, win_valid=0, then IDLE. A new start is accepted in the following IDLE cycle.
- start while busy: ignored; frame_reg is not reloaded. img_in changes after capture have no effect.
- Full frame scan with win_ready held at 1: start at cycle t, windows on t+1 .. t+W*H, done at t+W*H+1.
- kernalSize=1 degenerates to a pixel streamer. Pad width (kernalSize-1)/2 is implicit in img_in.
- No arithmetic on pixel data. Counters are unsigned, with no wrap beyond their terminal values.

Decomposition:
- Shared package holds the state encoding (IDLE/SCAN/DONE), the derived-width functions for PW/PH, and the window/frame bit-slice index functions. The padding block and the convolution stage reuse the same layout functions.
- One sub-module is natural: window_mux. It is combinational and maps frame_reg plus row/col to win_out. The FSM and counters stay in the top.

Test Plan:
- Config W=H=K=3, wordlength=8, unpadded pixels 1..9 row-major, padded to 5x5; start pulse, win_ready=1.
  - First window (0,0): elements 0..8 = 0,0,0,0,1,2,0,4,5.
  - Window (1,1) = 1..9.
  - Window (2,2) = 5,6,0,8,9,0,0,0,0.
  - Exactly 9 windows, done at cycle t+10.
- Same frame with win_ready toggled 1,0,0,1,…: each window held stable across stall cycles; no window duplicated or skipped; 9 transfers, then a single done pulse.
- Pulse start again at window 4 with a different img_in: it is ignored, and the remaining windows come from the original frame.
- Assert rst_n=0 for one cycle after window 5: the next cycle shows win_valid=0, busy=0, done=0, win_out=0. A new start then scans from (0,0).
- W=4, H=2, K=5, wordlength=16:
  - Window count is 8.
  - win_row/win_col sequence is (0,0)…(0,3),(1,0)…(1,3).
  - Window (0,0) is zero in its top 2 rows and left 2 columns.
- Assert start and rst_n=0 in the same cycle: the block stays in IDLE with no capture.
